stage_me: RTL and testbench

- Memory-access pipeline stage directly downstream of the execute stage; consumes its registered outputs (memOp, wdOp, exResult, regData2, pcPlus, imm).
- Issues load/store transactions on a req/ack data-memory port, aligns and extends load data, and stalls upstream while a transaction is outstanding.
- Presents a registered bundle to the write-back stage.

---
 rtl/stage_me_pkg.sv | 52 +++++
 rtl/stage_me_if.sv | 13 +
 rtl/stage_me_load_ext.sv | 32 +++
 rtl/stage_me.sv | 166 ++++++++++++++++
 tb/tb_stage_me.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_me_pkg.sv
// Shared definitions for the memory-access stage: memOp field positions, funct3 codes,
// the write-back bundle and the store-lane and fault helpers.
package stage_me_pkg;

    localparam int BUS_W     = 32;
    localparam int MEM_EN    = 0;
    localparam int MEM_WR    = 1;
    localparam int MEM_F3_LO = 2;
    localparam int MEM_F3_HI = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic [7:0]       wd_op;
        logic [BUS_W-1:0] ex_result;
        logic [BUS_W-1:0] pc_plus;
        logic [BUS_W-1:0] imm;
    } wb_bundle_t;

    function automatic logic mem_fault(input logic [2:0] f3, input logic wr, input logic [1:0] off);
        logic illegal;
        logic misaligned;
        illegal    = wr ? (f3[2] || f3 == 3'b011)
                        : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        misaligned = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
        return illegal || misaligned;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [BUS_W-1:0] store_wdata(input logic [2:0] f3, input logic [BUS_W-1:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/stage_me_if.sv
// Request/acknowledge data-memory port between the memory stage and the data memory.
interface stage_me_if;
    logic                             req;
    logic                             we;
    logic [stage_me_pkg::BUS_W-1:0]   addr;
    logic [stage_me_pkg::BUS_W-1:0]   wdata;
    logic [3:0]                       be;
    logic [stage_me_pkg::BUS_W-1:0]   rdata;
    logic                             ack;

    modport master (output req, we, addr, wdata, be, input rdata, ack);
    modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/stage_me_load_ext.sv
// Load data alignment: picks the byte/half addressed by the latched offset and
// sign- or zero-extends it according to funct3.
module stage_me_load_ext
    import stage_me_pkg::*;
(
    input  logic [2:0]       funct3,
    input  logic [1:0]       offset,
    input  logic [BUS_W-1:0] rdata,
    output logic [BUS_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/stage_me.sv
// Memory-access pipeline stage: issues loads/stores on the req/ack port, stalls upstream
// while a transaction is outstanding and registers the bundle handed to write-back.
//
// state  | meaning
// IDLE   | accepting ops from execute; non-memory ops pass straight through
// WAIT   | request outstanding, address/data held until dmem ack
module stage_me
    import stage_me_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [4:0]       memOpIn,
    input  logic [7:0]       wdOpIn,
    input  logic [BUS_W-1:0] exResultIn,
    input  logic [BUS_W-1:0] regData2In,
    input  logic [BUS_W-1:0] pcPlusIn,
    input  logic [BUS_W-1:0] immIn,
    output logic             stallOut,
    stage_me_if.master       dmem,
    output logic [BUS_W-1:0] memDataOut,
    output logic [BUS_W-1:0] exResultOut,
    output logic [BUS_W-1:0] pcPlusOut,
    output logic [BUS_W-1:0] immOut,
    output logic [7:0]       wdOpOut,
    output logic             memFaultOut
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [BUS_W-1:0] addr_q, addr_d;
    logic [BUS_W-1:0] wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic             discard_q, discard_d;
    wb_bundle_t       held_q, held_d;
    wb_bundle_t       out_q, out_d;
    logic [BUS_W-1:0] mem_data_q, mem_data_d;
    logic             fault_q, fault_d;

    logic             mem_en;
    logic             mem_wr;
    logic [2:0]       mem_f3;
    logic             in_fault;
    wb_bundle_t       in_bundle;
    logic [BUS_W-1:0] load_data;

    assign mem_en    = memOpIn[MEM_EN];
    assign mem_wr    = memOpIn[MEM_WR];
    assign mem_f3    = memOpIn[MEM_F3_HI:MEM_F3_LO];
    assign in_fault  = mem_fault(mem_f3, mem_wr, exResultIn[1:0]);
    assign in_bundle = {wdOpIn, exResultIn, pcPlusIn, immIn};

    stage_me_load_ext u_load_ext (
        .funct3 (f3_q),
        .offset (off_q),
        .rdata  (dmem.rdata),
        .data   (load_data)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        off_d      = off_q;
        discard_d  = discard_q;
        held_d     = held_q;
        out_d      = '0;
        mem_data_d = '0;
        fault_d    = 1'b0;
        stallOut   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    out_d = '0;
                end else if (!mem_en) begin
                    out_d = in_bundle;
                end else if (in_fault) begin
                    fault_d = 1'b1;
                end else begin
                    stallOut  = 1'b1;
                    state_d   = S_WAIT;
                    req_d     = 1'b1;
                    we_d      = mem_wr;
                    addr_d    = {exResultIn[BUS_W-1:2], 2'b00};
                    be_d      = mem_wr ? store_be(mem_f3, exResultIn[1:0]) : 4'b1111;
                    wdata_d   = mem_wr ? store_wdata(mem_f3, regData2In) : '0;
                    f3_d      = mem_f3;
                    off_d     = exResultIn[1:0];
                    held_d    = in_bundle;
                    discard_d = 1'b0;
                end
            end
            S_WAIT: begin
                stallOut = !dmem.ack;
                if (dmem.ack) begin
                    state_d   = S_IDLE;
                    req_d     = 1'b0;
                    discard_d = 1'b0;
                    // A flush seen in the ack cycle itself still turns the result into a bubble.
                    if (!(discard_q || flush)) begin
                        out_d      = held_q;
                        mem_data_d = we_q ? '0 : load_data;
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            discard_q  <= 1'b0;
            held_q     <= '0;
            out_q      <= '0;
            mem_data_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            discard_q  <= discard_d;
            held_q     <= held_d;
            out_q      <= out_d;
            mem_data_q <= mem_data_d;
            fault_q    <= fault_d;
        end
    end

    assign dmem.req    = req_q;
    assign dmem.we     = we_q;
    assign dmem.addr   = addr_q;
    assign dmem.wdata  = wdata_q;
    assign dmem.be     = be_q;

    assign wdOpOut     = out_q.wd_op;
    assign exResultOut = out_q.ex_result;
    assign pcPlusOut   = out_q.pc_plus;
    assign immOut      = out_q.imm;
    assign memDataOut  = mem_data_q;
    assign memFaultOut = fault_q;

endmodule

// File: tb/tb_stage_me.sv
// Directed bench for stage_me: pass-through, store lanes, load extension, faults,
// flush during a transaction and reset mid-transaction.
module tb_stage_me;
    logic        clk;
    logic        rst;
    logic        flush;
    logic [4:0]  memOpIn;
    logic [7:0]  wdOpIn;
    logic [31:0] exResultIn, regData2In, pcPlusIn, immIn;
    logic        stallOut;
    logic [31:0] memDataOut, exResultOut, pcPlusOut, immOut;
    logic [7:0]  wdOpOut;
    logic        memFaultOut;
    int          checks;
    int          errors;

    stage_me_if dmem_bus ();

    stage_me dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .memOpIn     (memOpIn),
        .wdOpIn      (wdOpIn),
        .exResultIn  (exResultIn),
        .regData2In  (regData2In),
        .pcPlusIn    (pcPlusIn),
        .immIn       (immIn),
        .stallOut    (stallOut),
        .dmem        (dmem_bus),
        .memDataOut  (memDataOut),
        .exResultOut (exResultOut),
        .pcPlusOut   (pcPlusOut),
        .immOut      (immOut),
        .wdOpOut     (wdOpOut),
        .memFaultOut (memFaultOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] mop(input logic [2:0] f3, input logic wr);
        return {f3, wr, 1'b1};
    endfunction

    task automatic idle_inputs();
        memOpIn = '0; wdOpIn = '0; exResultIn = '0; regData2In = '0; pcPlusIn = '0; immIn = '0;
    endtask

    // Issues one memory op, answers it after wait_n non-ack WAIT cycles, and returns observations.
    // Returns at the negedge after the ack edge, where the result is visible.
    task automatic mem_txn(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] d,
                           input logic [7:0] wd, input int wait_n, input logic [31:0] rdata,
                           input logic flush_first, output int stalls, output logic req_seen,
                           output logic we_seen, output logic [31:0] addr_seen,
                           output logic [31:0] wdata_seen, output logic [3:0] be_seen,
                           output logic [7:0] wd_wait);
        @(negedge clk);
        memOpIn = op; exResultIn = addr; regData2In = d; wdOpIn = wd;
        pcPlusIn = addr + 32'd4; immIn = 32'h7;
        #1 stalls = int'(stallOut);
        @(negedge clk);
        idle_inputs();
        flush = flush_first;
        #1;
        req_seen = dmem_bus.req; we_seen = dmem_bus.we; addr_seen = dmem_bus.addr;
        wdata_seen = dmem_bus.wdata; be_seen = dmem_bus.be; wd_wait = wdOpOut;
        repeat (wait_n) begin
            stalls += int'(stallOut);
            @(negedge clk);
            flush = 1'b0;
            #1;
        end
        dmem_bus.rdata = rdata;
        dmem_bus.ack = 1'b1;
        #1 stalls += int'(stallOut);
        @(negedge clk);
        dmem_bus.ack = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; idle_inputs();
        dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (dmem_bus.req !== 1'b0 || stallOut !== 1'b0) begin
            errors++; $display("FAIL reset_req_stall: got req=%b stall=%b expected 0 0", dmem_bus.req, stallOut);
        end
        checks++;
        if ({wdOpOut, exResultOut, pcPlusOut, immOut, memDataOut, memFaultOut} !== '0) begin
            errors++; $display("FAIL reset_outputs: got wd=%h ex=%h mem=%h flt=%b expected all 0", wdOpOut, exResultOut, memDataOut, memFaultOut);
        end
        rst = 1'b1;
    endtask

    task automatic test_alu();
        int stall_seen = 0;
        @(negedge clk);
        memOpIn = '0; wdOpIn = 8'h5A; exResultIn = 32'h1234; pcPlusIn = 32'h44; immIn = 32'h8;
        #1 stall_seen += int'(stallOut);
        @(negedge clk);
        checks++;
        if (exResultOut !== 32'h1234 || wdOpOut !== 8'h5A || pcPlusOut !== 32'h44 || immOut !== 32'h8) begin
            errors++; $display("FAIL alu_pass1: got ex=%h wd=%h pc=%h imm=%h expected 1234 5a 44 8", exResultOut, wdOpOut, pcPlusOut, immOut);
        end
        checks++;
        if (memDataOut !== 32'h0 || memFaultOut !== 1'b0) begin
            errors++; $display("FAIL alu_memdata: got mem=%h flt=%b expected 0 0", memDataOut, memFaultOut);
        end
        wdOpIn = 8'hC3; exResultIn = 32'hFFFF0001;
        #1 stall_seen += int'(stallOut);
        @(negedge clk);
        checks++;
        if (exResultOut !== 32'hFFFF0001 || wdOpOut !== 8'hC3) begin
            errors++; $display("FAIL alu_pass2: got ex=%h wd=%h expected ffff0001 c3", exResultOut, wdOpOut);
        end
        checks++;
        if (stall_seen !== 0) begin
            errors++; $display("FAIL alu_stall: got %0d stall cycles expected 0", stall_seen);
        end
        idle_inputs();
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        wdOpIn = 8'h77; exResultIn = 32'hABCD; pcPlusIn = 32'h10; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; idle_inputs();
        checks++;
        if (wdOpOut !== 8'h0 || exResultOut !== 32'h0 || pcPlusOut !== 32'h0) begin
            errors++; $display("FAIL flush_idle: got wd=%h ex=%h pc=%h expected 0 0 0", wdOpOut, exResultOut, pcPlusOut);
        end
    endtask

    task automatic test_store_lanes();
        int stalls; logic req_s, we_s; logic [31:0] a_s, w_s; logic [3:0] be_s; logic [7:0] wd_w;
        mem_txn(mop(3'b000, 1'b1), 32'h103, 32'h123456A5, 8'h11, 3, 32'hFFFFFFFF, 1'b0,
                stalls, req_s, we_s, a_s, w_s, be_s, wd_w);
        checks++;
        if (req_s !== 1'b1 || we_s !== 1'b1 || a_s !== 32'h100) begin
            errors++; $display("FAIL sb_req: got req=%b we=%b addr=%h expected 1 1 100", req_s, we_s, a_s);
        end
        checks++;
        if (be_s !== 4'b1000 || w_s !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL sb_lanes: got be=%b wdata=%h expected 1000 a5a5a5a5", be_s, w_s);
        end
        checks++;
        if (stalls !== 4) begin
            errors++; $display("FAIL sb_stall_count: got %0d expected 4", stalls);
        end
        checks++;
        if (wd_w !== 8'h0) begin
            errors++; $display("FAIL sb_wait_bubble: got wd=%h expected 0", wd_w);
        end
        checks++;
        if (wdOpOut !== 8'h11 || exResultOut !== 32'h103 || pcPlusOut !== 32'h107 || immOut !== 32'h7 || memDataOut !== 32'h0) begin
            errors++; $display("FAIL sb_result: got wd=%h ex=%h pc=%h imm=%h mem=%h expected 11 103 107 7 0", wdOpOut, exResultOut, pcPlusOut, immOut, memDataOut);
        end
        checks++;
        if (dmem_bus.req !== 1'b0) begin
            errors++; $display("FAIL sb_req_drop: got req=%b expected 0", dmem_bus.req);
        end
        mem_txn(mop(3'b001, 1'b1), 32'h1002, 32'hCAFEBEEF, 8'h12, 0, 32'h0, 1'b0,
                stalls, req_s, we_s, a_s, w_s, be_s, wd_w);
        checks++;
        if (a_s !== 32'h1000 || be_s !== 4'b1100 || w_s !== 32'hBEEFBEEF || stalls !== 1) begin
            errors++; $display("FAIL sh_lanes: got addr=%h be=%b wdata=%h stalls=%0d expected 1000 1100 beefbeef 1", a_s, be_s, w_s, stalls);
        end
        mem_txn(mop(3'b010, 1'b1), 32'h20, 32'hCAFEBEEF, 8'h13, 1, 32'h0, 1'b0,
                stalls, req_s, we_s, a_s, w_s, be_s, wd_w);
        checks++;
        if (a_s !== 32'h20 || be_s !== 4'b1111 || w_s !== 32'hCAFEBEEF || stalls !== 2 || wdOpOut !== 8'h13) begin
            errors++; $display("FAIL sw_lanes: got addr=%h be=%b wdata=%h stalls=%0d wd=%h expected 20 1111 cafebeef 2 13", a_s, be_s, w_s, stalls, wdOpOut);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3 [5];
        logic [31:0] ad [5];
        logic [31:0] rd [5];
        logic [31:0] ex [5];
        int stalls; logic req_s, we_s; logic [31:0] a_s, w_s; logic [3:0] be_s; logic [7:0] wd_w;
        f3[0] = 3'b000; ad[0] = 32'h102; rd[0] = 32'h00800000; ex[0] = 32'hFFFFFF80;
        f3[1] = 3'b100; ad[1] = 32'h102; rd[1] = 32'h00800000; ex[1] = 32'h00000080;
        f3[2] = 3'b001; ad[2] = 32'h102; rd[2] = 32'h80010000; ex[2] = 32'hFFFF8001;
        f3[3] = 3'b101; ad[3] = 32'h102; rd[3] = 32'h80010000; ex[3] = 32'h00008001;
        f3[4] = 3'b010; ad[4] = 32'h104; rd[4] = 32'h89ABCDEF; ex[4] = 32'h89ABCDEF;
        for (int i = 0; i < 5; i++) begin
            mem_txn(mop(f3[i], 1'b0), ad[i], 32'h0, 8'h20 + 8'(i), i % 2, rd[i], 1'b0,
                    stalls, req_s, we_s, a_s, w_s, be_s, wd_w);
            checks++;
            if (memDataOut !== ex[i] || wdOpOut !== 8'h20 + 8'(i) || we_s !== 1'b0 || a_s !== {ad[i][31:2], 2'b00}) begin
                errors++; $display("FAIL load_ext[%0d]: got mem=%h wd=%h we=%b addr=%h expected %h %h 0 %h", i, memDataOut, wdOpOut, we_s, a_s, ex[i], 8'h20 + 8'(i), {ad[i][31:2], 2'b00});
            end
        end
    endtask

    task automatic test_fault();
        logic [4:0]  op [4];
        logic [31:0] ad [4];
        op[0] = mop(3'b010, 1'b0); ad[0] = 32'h102;
        op[1] = mop(3'b001, 1'b1); ad[1] = 32'h201;
        op[2] = mop(3'b100, 1'b1); ad[2] = 32'h200;
        op[3] = mop(3'b011, 1'b0); ad[3] = 32'h200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            memOpIn = op[i]; exResultIn = ad[i]; wdOpIn = 8'h44;
            #1;
            checks++;
            if (stallOut !== 1'b0) begin
                errors++; $display("FAIL fault_stall[%0d]: got %b expected 0", i, stallOut);
            end
            @(negedge clk);
            memOpIn = '0; exResultIn = 32'h55; wdOpIn = 8'h33;
            checks++;
            if (dmem_bus.req !== 1'b0 || wdOpOut !== 8'h0 || memFaultOut !== 1'b1) begin
                errors++; $display("FAIL fault_resp[%0d]: got req=%b wd=%h flt=%b expected 0 0 1", i, dmem_bus.req, wdOpOut, memFaultOut);
            end
            @(negedge clk);
            checks++;
            if (memFaultOut !== 1'b0 || wdOpOut !== 8'h33 || exResultOut !== 32'h55) begin
                errors++; $display("FAIL fault_clear[%0d]: got flt=%b wd=%h ex=%h expected 0 33 55", i, memFaultOut, wdOpOut, exResultOut);
            end
            idle_inputs();
        end
    endtask

    task automatic test_flush_wait();
        int stalls; logic req_s, we_s; logic [31:0] a_s, w_s; logic [3:0] be_s; logic [7:0] wd_w;
        mem_txn(mop(3'b010, 1'b0), 32'h200, 32'h0, 8'h66, 2, 32'h11223344, 1'b1,
                stalls, req_s, we_s, a_s, w_s, be_s, wd_w);
        checks++;
        if (stalls !== 3) begin
            errors++; $display("FAIL flush_wait_stall: got %0d expected 3", stalls);
        end
        checks++;
        if (wdOpOut !== 8'h0 || memDataOut !== 32'h0 || exResultOut !== 32'h0) begin
            errors++; $display("FAIL flush_wait_bubble: got wd=%h mem=%h ex=%h expected 0 0 0", wdOpOut, memDataOut, exResultOut);
        end
        mem_txn(mop(3'b010, 1'b0), 32'h204, 32'h0, 8'h67, 0, 32'h55667788, 1'b0,
                stalls, req_s, we_s, a_s, w_s, be_s, wd_w);
        checks++;
        if (wdOpOut !== 8'h67 || memDataOut !== 32'h55667788 || stalls !== 1 || a_s !== 32'h204) begin
            errors++; $display("FAIL flush_next_op: got wd=%h mem=%h stalls=%0d addr=%h expected 67 55667788 1 204", wdOpOut, memDataOut, stalls, a_s);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        memOpIn = mop(3'b010, 1'b0); exResultIn = 32'h300; wdOpIn = 8'h99;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (dmem_bus.req !== 1'b1 || stallOut !== 1'b1) begin
            errors++; $display("FAIL rstmid_wait: got req=%b stall=%b expected 1 1", dmem_bus.req, stallOut);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (dmem_bus.req !== 1'b0 || stallOut !== 1'b0 || wdOpOut !== 8'h0 || exResultOut !== 32'h0) begin
            errors++; $display("FAIL rstmid_abandon: got req=%b stall=%b wd=%h ex=%h expected 0 0 0 0", dmem_bus.req, stallOut, wdOpOut, exResultOut);
        end
        @(negedge clk);
        rst = 1'b1; exResultIn = 32'h77;
        @(negedge clk);
        dmem_bus.rdata = 32'hFFFFFFFF; dmem_bus.ack = 1'b1;
        #1;
        checks++;
        if (stallOut !== 1'b0) begin
            errors++; $display("FAIL rstmid_late_ack_stall: got %b expected 0", stallOut);
        end
        @(negedge clk);
        dmem_bus.ack = 1'b0;
        checks++;
        if (dmem_bus.req !== 1'b0 || memDataOut !== 32'h0 || exResultOut !== 32'h77 || wdOpOut !== 8'h0) begin
            errors++; $display("FAIL rstmid_late_ack: got req=%b mem=%h ex=%h wd=%h expected 0 0 77 0", dmem_bus.req, memDataOut, exResultOut, wdOpOut);
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu();
        test_flush_idle();
        test_store_lanes();
        test_load_ext();
        test_fault();
        test_flush_wait();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
